// File: rtl/rv32_pkg.sv
// Shared RV32IM pipeline constants: reset PC, bubble word, opcodes, fetch FSM encoding.
package rv32_pkg;

    localparam logic [31:0] RV_RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] RV_NOP_INSTR = 32'h0000_0013;

    localparam logic [6:0] OP_LUI    = 7'h37;
    localparam logic [6:0] OP_AUIPC  = 7'h17;
    localparam logic [6:0] OP_JAL    = 7'h6F;
    localparam logic [6:0] OP_JALR   = 7'h67;
    localparam logic [6:0] OP_BRANCH = 7'h63;
    localparam logic [6:0] OP_LOAD   = 7'h03;
    localparam logic [6:0] OP_STORE  = 7'h23;
    localparam logic [6:0] OP_IMM    = 7'h13;
    localparam logic [6:0] OP_REG    = 7'h33;

    localparam logic [1:0] ST_RUN  = 2'd0;
    localparam logic [1:0] ST_MISS = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;

    typedef enum logic [1:0] {
        FS_RUN  = ST_RUN,
        FS_MISS = ST_MISS,
        FS_HOLD = ST_HOLD
    } fetch_state_e;

    function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry {pc, instr, valid} buffer catching a fetch that completes while decode is stalled.
module fetch_skid_buf (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic        drain,
    input  logic        clear,
    input  logic [31:0] pc_in,
    input  logic [31:0] instr_in,
    output logic        valid,
    output logic [31:0] pc,
    output logic [31:0] instr
);

    logic        valid_q, valid_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;

    // Next entry: a redirect clear beats a load, which beats a drain.
    always_comb begin
        valid_d = valid_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        if (clear) begin
            valid_d = 1'b0;
        end else if (load) begin
            valid_d = 1'b1;
            pc_d    = pc_in;
            instr_d = instr_in;
        end else if (drain) begin
            valid_d = 1'b0;
        end else begin
            valid_d = valid_q;
        end
    end

    // Entry storage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            pc_q    <= 32'h0000_0000;
            instr_q <= 32'h0000_0000;
        end else begin
            valid_q <= valid_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
        end
    end

    assign valid = valid_q;
    assign pc    = pc_q;
    assign instr = instr_q;

endmodule

// File: rtl/fetch_stage.sv
// RV32IM IF stage plus IF/ID register: PC, imem handshake, miss/stall/redirect handling.
// Optional FETCH_PERF_CNT_EN adds PERF_FETCHED / PERF_WAIT_CYC counters.
module fetch_stage
    import rv32_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = RV_RESET_PC,
    parameter logic [31:0] NOP_INSTR = RV_NOP_INSTR
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        STALL,
    input  logic        BRANCH_TAKEN,
    input  logic [31:0] BRANCH_TARGET,
    output logic        IMEM_READ,
    output logic [31:0] IMEM_ADDR,
    input  logic        IMEM_BUSYWAIT,
    input  logic [31:0] IMEM_INSTR,
    output logic        ID_VALID,
    output logic [31:0] ID_PC,
    output logic [31:0] ID_PC4,
    output logic [31:0] ID_INSTR,
    output logic [6:0]  OPCODE,
    output logic [2:0]  FUNC3,
    output logic [6:0]  FUNC7,
    output logic        FETCH_STALL
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] PERF_FETCHED,
    output logic [31:0] PERF_WAIT_CYC
`endif
);

    logic [1:0]  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        kill_q, kill_d;
    logic [31:0] tgt_q, tgt_d;
    logic        id_valid_q, id_valid_d;
    logic [31:0] id_pc_q, id_pc_d, id_pc4_q, id_pc4_d, id_instr_q, id_instr_d;

    logic        read_s, id_load_s, id_new_valid_s;
    logic [31:0] id_new_pc_s, id_new_instr_s;
    logic        skid_load_s, skid_drain_s, skid_clear_s, skid_valid_s;
    logic [31:0] skid_pc_s, skid_instr_s;

    fetch_skid_buf u_skid (
        .clk      (CLK),
        .rst_n    (RESET),
        .load     (skid_load_s),
        .drain    (skid_drain_s),
        .clear    (skid_clear_s),
        .pc_in    (pc_q),
        .instr_in (IMEM_INSTR),
        .valid    (skid_valid_s),
        .pc       (skid_pc_s),
        .instr    (skid_instr_s)
    );

    // Fetch FSM; an IF/ID load with id_new_valid_s=0 is a bubble.
    always_comb begin
        state_d        = state_q;
        pc_d           = pc_q;
        kill_d         = kill_q;
        tgt_d          = tgt_q;
        read_s         = 1'b0;
        id_load_s      = 1'b0;
        id_new_valid_s = 1'b0;
        id_new_pc_s    = id_pc_q;
        id_new_instr_s = NOP_INSTR;
        skid_load_s    = 1'b0;
        skid_drain_s   = 1'b0;
        skid_clear_s   = 1'b0;
        case (state_q)
            ST_RUN: begin
                read_s = !STALL || BRANCH_TAKEN;
                if (BRANCH_TAKEN) begin
                    id_load_s    = 1'b1;
                    skid_clear_s = 1'b1;
                    pc_d         = word_align(BRANCH_TARGET);
                end else if (STALL) begin
                    pc_d = pc_q;
                end else if (IMEM_BUSYWAIT) begin
                    state_d = ST_MISS;
                end else begin
                    id_load_s      = 1'b1;
                    id_new_valid_s = 1'b1;
                    id_new_pc_s    = pc_q;
                    id_new_instr_s = IMEM_INSTR;
                    pc_d           = pc_plus4(pc_q);
                end
            end
            ST_MISS: begin
                read_s = 1'b1;
                if (!IMEM_BUSYWAIT) begin
                    if (BRANCH_TAKEN || kill_q) begin
                        // wrong-path word: drop it and resume at the newest target
                        id_load_s    = 1'b1;
                        skid_clear_s = 1'b1;
                        pc_d         = BRANCH_TAKEN ? word_align(BRANCH_TARGET) : tgt_q;
                        kill_d       = 1'b0;
                        state_d      = ST_RUN;
                    end else if (STALL) begin
                        skid_load_s = 1'b1;
                        pc_d        = pc_plus4(pc_q);
                        state_d     = ST_HOLD;
                    end else begin
                        id_load_s      = 1'b1;
                        id_new_valid_s = 1'b1;
                        id_new_pc_s    = pc_q;
                        id_new_instr_s = IMEM_INSTR;
                        pc_d           = pc_plus4(pc_q);
                        state_d        = ST_RUN;
                    end
                end else if (BRANCH_TAKEN) begin
                    id_load_s    = 1'b1;
                    skid_clear_s = 1'b1;
                    kill_d       = 1'b1;
                    tgt_d        = word_align(BRANCH_TARGET);
                end else begin
                    state_d = ST_MISS;
                end
            end
            ST_HOLD: begin
                if (BRANCH_TAKEN) begin
                    id_load_s    = 1'b1;
                    skid_clear_s = 1'b1;
                    pc_d         = word_align(BRANCH_TARGET);
                    state_d      = ST_RUN;
                end else if (!STALL) begin
                    id_load_s      = 1'b1;
                    id_new_valid_s = skid_valid_s;
                    id_new_pc_s    = skid_pc_s;
                    id_new_instr_s = skid_instr_s;
                    skid_drain_s   = 1'b1;
                    state_d        = ST_RUN;
                end else begin
                    state_d = ST_HOLD;
                end
            end
            default: begin
                state_d = ST_RUN;
                kill_d  = 1'b0;
            end
        endcase

        id_valid_d = id_load_s ? id_new_valid_s          : id_valid_q;
        id_pc_d    = id_load_s ? id_new_pc_s             : id_pc_q;
        id_pc4_d   = id_load_s ? pc_plus4(id_new_pc_s)   : id_pc4_q;
        id_instr_d = id_load_s ? id_new_instr_s          : id_instr_q;
    end

    // PC, FSM and IF/ID registers.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q    <= ST_RUN;
            pc_q       <= RESET_PC;
            kill_q     <= 1'b0;
            tgt_q      <= 32'h0000_0000;
            id_valid_q <= 1'b0;
            id_pc_q    <= 32'h0000_0000;
            id_pc4_q   <= 32'h0000_0004;
            id_instr_q <= NOP_INSTR;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            kill_q     <= kill_d;
            tgt_q      <= tgt_d;
            id_valid_q <= id_valid_d;
            id_pc_q    <= id_pc_d;
            id_pc4_q   <= id_pc4_d;
            id_instr_q <= id_instr_d;
        end
    end

    assign IMEM_READ   = RESET & read_s;
    assign IMEM_ADDR   = pc_q;
    assign FETCH_STALL = (state_q == ST_MISS);
    assign ID_VALID    = id_valid_q;
    assign ID_PC       = id_pc_q;
    assign ID_PC4      = id_pc4_q;
    assign ID_INSTR    = id_instr_q;
    assign OPCODE      = id_instr_q[6:0];
    assign FUNC3       = id_instr_q[14:12];
    assign FUNC7       = id_instr_q[31:25];

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetched_q, perf_fetched_d, perf_wait_q, perf_wait_d;

    // Wrapping event counters.
    always_comb begin
        perf_fetched_d = perf_fetched_q;
        perf_wait_d    = perf_wait_q;
        if (id_load_s && id_new_valid_s) begin
            perf_fetched_d = perf_fetched_q + 32'd1;
        end else begin
            perf_fetched_d = perf_fetched_q;
        end
        if (state_q == ST_MISS) begin
            perf_wait_d = perf_wait_q + 32'd1;
        end else begin
            perf_wait_d = perf_wait_q;
        end
    end

    // Counter storage.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            perf_fetched_q <= 32'h0000_0000;
            perf_wait_q    <= 32'h0000_0000;
        end else begin
            perf_fetched_q <= perf_fetched_d;
            perf_wait_q    <= perf_wait_d;
        end
    end

    assign PERF_FETCHED  = perf_fetched_q;
    assign PERF_WAIT_CYC = perf_wait_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios plus randomized stall/redirect/wait traffic.
module tb_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        CLK = 1'b0;
    logic        RESET, STALL, BRANCH_TAKEN, IMEM_BUSYWAIT;
    logic [31:0] BRANCH_TARGET, IMEM_INSTR;
    logic        IMEM_READ, ID_VALID, FETCH_STALL;
    logic [31:0] IMEM_ADDR, ID_PC, ID_PC4, ID_INSTR;
    logic [6:0]  OPCODE, FUNC7;
    logic [2:0]  FUNC3;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] PERF_FETCHED, PERF_WAIT_CYC;
`endif

    int checks   = 0;
    int failures = 0;

    // reference model state
    bit          m_pending, m_kill, m_skv, m_idv;
    logic [31:0] m_pc, m_ktgt, m_skpc, m_skinstr, m_idpc, m_idinstr;
    logic [31:0] m_fetched, m_wait;

    fetch_stage dut (
        .CLK           (CLK),
        .RESET         (RESET),
        .STALL         (STALL),
        .BRANCH_TAKEN  (BRANCH_TAKEN),
        .BRANCH_TARGET (BRANCH_TARGET),
        .IMEM_READ     (IMEM_READ),
        .IMEM_ADDR     (IMEM_ADDR),
        .IMEM_BUSYWAIT (IMEM_BUSYWAIT),
        .IMEM_INSTR    (IMEM_INSTR),
        .ID_VALID      (ID_VALID),
        .ID_PC         (ID_PC),
        .ID_PC4        (ID_PC4),
        .ID_INSTR      (ID_INSTR),
        .OPCODE        (OPCODE),
        .FUNC3         (FUNC3),
        .FUNC7         (FUNC7),
        .FETCH_STALL   (FETCH_STALL)
`ifdef FETCH_PERF_CNT_EN
        ,
        .PERF_FETCHED  (PERF_FETCHED),
        .PERF_WAIT_CYC (PERF_WAIT_CYC)
`endif
    );

    always #5 CLK = ~CLK;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0000_0000) return 32'h0050_0093;
        else return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pending = 1'b0; m_kill = 1'b0; m_skv = 1'b0; m_idv = 1'b0;
        m_pc = 32'h0; m_ktgt = 32'h0; m_skpc = 32'h0; m_skinstr = 32'h0;
        m_idpc = 32'h0; m_idinstr = NOP; m_fetched = 32'h0; m_wait = 32'h0;
    endtask

    function automatic logic model_read(input bit s, input bit b);
        if (m_pending) return 1'b1;
        else if (m_skv) return 1'b0;
        else return !s || b;
    endfunction

    task automatic id_bubble();
        m_idv = 1'b0;
        m_idinstr = NOP;
    endtask

    task automatic id_word(input logic [31:0] pc, input logic [31:0] w);
        m_idv = 1'b1; m_idpc = pc; m_idinstr = w; m_fetched++;
    endtask

    // One clock of the fetch rules: a redirect always bubbles IF/ID and empties the skid slot.
    task automatic model_step(input bit s, input bit b, input logic [31:0] t, input bit bw);
        logic [31:0] ta;
        ta = {t[31:2], 2'b00};
        if (m_pending) m_wait++;
        if (m_pending) begin
            if (!bw) begin
                m_pending = 1'b0;
                if (m_kill || b) begin
                    id_bubble();
                    m_pc = b ? ta : m_ktgt;
                    m_kill = 1'b0;
                end else if (s) begin
                    m_skv = 1'b1; m_skpc = m_pc; m_skinstr = mem_word(m_pc);
                    m_pc = m_pc + 32'd4;
                end else begin
                    id_word(m_pc, mem_word(m_pc));
                    m_pc = m_pc + 32'd4;
                end
            end else if (b) begin
                m_kill = 1'b1; m_ktgt = ta; id_bubble();
            end
        end else if (m_skv) begin
            if (b) begin
                id_bubble(); m_skv = 1'b0; m_pc = ta;
            end else if (!s) begin
                id_word(m_skpc, m_skinstr); m_skv = 1'b0;
            end
        end else if (b) begin
            id_bubble(); m_pc = ta;
        end else if (!s) begin
            if (bw) m_pending = 1'b1;
            else begin
                id_word(m_pc, mem_word(m_pc));
                m_pc = m_pc + 32'd4;
            end
        end
    endtask

    task automatic compare_all();
        chk("id_valid", {31'd0, ID_VALID}, {31'd0, m_idv});
        chk("id_instr", ID_INSTR, m_idinstr);
        chk("opcode", {25'd0, OPCODE}, {25'd0, m_idinstr[6:0]});
        chk("func3", {29'd0, FUNC3}, {29'd0, m_idinstr[14:12]});
        chk("func7", {25'd0, FUNC7}, {25'd0, m_idinstr[31:25]});
        if (m_idv) begin
            chk("id_pc", ID_PC, m_idpc);
            chk("id_pc4", ID_PC4, m_idpc + 32'd4);
        end
        chk("imem_addr", IMEM_ADDR, m_pc);
        chk("fetch_stall", {31'd0, FETCH_STALL}, {31'd0, m_pending});
`ifdef FETCH_PERF_CNT_EN
        chk("perf_fetched", PERF_FETCHED, m_fetched);
        chk("perf_wait", PERF_WAIT_CYC, m_wait);
`endif
    endtask

    task automatic cyc(input bit s, input bit b, input logic [31:0] t, input bit bw);
        STALL = s; BRANCH_TAKEN = b; BRANCH_TARGET = t; IMEM_BUSYWAIT = bw;
        IMEM_INSTR = mem_word(IMEM_ADDR);
        #1;
        chk("imem_read", {31'd0, IMEM_READ}, {31'd0, model_read(s, b)});
        @(posedge CLK);
        model_step(s, b, t, bw);
        #1;
        compare_all();
    endtask

    initial begin
        int stall_cnt;
        RESET = 1'b0; STALL = 1'b0; BRANCH_TAKEN = 1'b0; BRANCH_TARGET = 32'h0;
        IMEM_BUSYWAIT = 1'b0; IMEM_INSTR = 32'h0;
        model_reset();
        repeat (2) @(posedge CLK);
        #1;
        chk("rst_id_valid", {31'd0, ID_VALID}, 32'd0);
        chk("rst_id_instr", ID_INSTR, 32'h0000_0013);
        chk("rst_id_pc", ID_PC, 32'h0);
        chk("rst_id_pc4", ID_PC4, 32'h4);
        chk("rst_fetch_stall", {31'd0, FETCH_STALL}, 32'd0);
        chk("rst_imem_read", {31'd0, IMEM_READ}, 32'd0);
        @(negedge CLK);
        RESET = 1'b1;

        // zero-wait fetch from 0x0
        chk("t1_addr", IMEM_ADDR, 32'h0);
        cyc(1'b0, 1'b0, 32'h0, 1'b0);
        chk("t1_valid", {31'd0, ID_VALID}, 32'd1);
        chk("t1_instr", ID_INSTR, 32'h0050_0093);
        chk("t1_opcode", {25'd0, OPCODE}, 32'h13);
        chk("t1_pc4", ID_PC4, 32'h4);
        cyc(1'b0, 1'b0, 32'h0, 1'b0);

        // three wait states at 0x8
        stall_cnt = 0;
        for (int k = 0; k < 3; k++) begin
            cyc(1'b0, 1'b0, 32'h0, 1'b1);
            chk("t2_addr_hold", IMEM_ADDR, 32'h8);
            chk("t2_id_hold", ID_PC, 32'h4);
            stall_cnt += int'(FETCH_STALL);
        end
        cyc(1'b0, 1'b0, 32'h0, 1'b0);
        chk("t2_stall_cycles", stall_cnt, 32'd3);
        chk("t2_id_pc", ID_PC, 32'h8);
`ifdef FETCH_PERF_CNT_EN
        chk("t6_perf_fetched", PERF_FETCHED, 32'd3);
        chk("t6_perf_wait", PERF_WAIT_CYC, 32'd3);
`endif

        // miss at 0xC completing under STALL lands in the skid slot
        cyc(1'b0, 1'b0, 32'h0, 1'b1);
        cyc(1'b1, 1'b0, 32'h0, 1'b0);
        chk("t3_id_hold", ID_PC, 32'h8);
        chk("t3_read_off", {31'd0, IMEM_READ}, 32'd0);
        cyc(1'b1, 1'b0, 32'h0, 1'b0);
        cyc(1'b0, 1'b0, 32'h0, 1'b0);
        chk("t3_skid_pc", ID_PC, 32'hC);
        chk("t3_skid_instr", ID_INSTR, mem_word(32'hC));
        chk("t3_next_addr", IMEM_ADDR, 32'h10);

        // redirect during miss at 0x10
        cyc(1'b0, 1'b0, 32'h0, 1'b1);
        cyc(1'b0, 1'b1, 32'h40, 1'b1);
        chk("t4_bubble", {31'd0, ID_VALID}, 32'd0);
        cyc(1'b0, 1'b0, 32'h0, 1'b0);
        chk("t4_discard", {31'd0, ID_VALID}, 32'd0);
        chk("t4_target", IMEM_ADDR, 32'h40);

        // redirect with STALL, target low bits masked, then wrap
        cyc(1'b1, 1'b1, 32'hFFFF_FFFF, 1'b0);
        chk("t5_bubble_instr", ID_INSTR, 32'h0000_0013);
        chk("t5_target", IMEM_ADDR, 32'hFFFF_FFFC);
        cyc(1'b0, 1'b0, 32'h0, 1'b0);
        chk("t5_wrap_pc", ID_PC, 32'hFFFF_FFFC);
        chk("t5_wrap_pc4", ID_PC4, 32'h0);
        chk("t5_wrap_addr", IMEM_ADDR, 32'h0);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] t;
            t = $urandom();
            if ($urandom_range(0, 7) == 0) t = 32'hFFFF_FFF0 | {28'd0, t[3:0]};
            cyc($urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0, t, $urandom_range(0, 2) == 0);
        end

        // reset in the middle of a miss abandons it
        cyc(1'b0, 1'b0, 32'h0, 1'b0);
        cyc(1'b0, 1'b0, 32'h0, 1'b0);
        cyc(1'b0, 1'b0, 32'h0, 1'b1);
        RESET = 1'b0; IMEM_BUSYWAIT = 1'b0;
        model_reset();
        #1;
        chk("mr_read", {31'd0, IMEM_READ}, 32'd0);
        chk("mr_fetch_stall", {31'd0, FETCH_STALL}, 32'd0);
        chk("mr_valid", {31'd0, ID_VALID}, 32'd0);
        @(posedge CLK);
        @(negedge CLK);
        RESET = 1'b1;
        compare_all();
        cyc(1'b0, 1'b0, 32'h0, 1'b0);
        chk("mr_first_pc", ID_PC, 32'h0);
        chk("mr_first_instr", ID_INSTR, 32'h0050_0093);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
